lfsr_rand_arbiter: RTL and testbench
====================================

Name: lfsr_rand_arbiter

Overview:
- Shares one Fibonacci LFSR among NREQ requesters, round-robin.
- Each grant delivers a WIDTH-bit word produced by stepping the LFSR STEPS times, so every delivered bit is fresh.
- Owns seeding (load_seed/seed) and the zero-seed guard.
- Sits between the random-number consumers and the shift-register datapath, and is the only block that sequences it.

Parameters:
- WIDTH, 8: LFSR and word width; supported values are 8 and 17.
- NREQ, 4: number of requesters, 2..8.
- STEPS, WIDTH: LFSR shifts per delivered word, 1..WIDTH.
- RST_SEED, 1: LFSR value after reset; must be nonzero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_seed  in  1  load seed into the LFSR.
- seed  in  WIDTH  seed value, sampled when load_seed=1.
- req  in  NREQ  per-requester request level; held until gnt.
- gnt  out  NREQ  one-hot grant pulse, coincident with rand_valid.
- rand_out  out  WIDTH  delivered random word.
- rand_valid  out  1  rand_out valid for exactly one cycle.
- busy  out  1  high in RUN and DELIVER.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, LFSR=RST_SEED, rr_ptr=0, step_cnt=0.
  - gnt=0, rand_out=0, rand_valid=0, busy=0.
  - Reset mid-RUN or mid-DELIVER aborts the operation; no grant is issued.
- LFSR step:
  - fb = XOR-reduce(lfsr & TAP_MASK); lfsr <= {lfsr[WIDTH-2:0], fb}.
  - TAP_MASK for WIDTH=8 is 8'hB8 (x^8+x^6+x^5+x^4+1).
  - TAP_MASK for WIDTH=17 is 17'h12000 (x^17+x^14+1).
- Seed load:
  - load_seed=1 loads seed, or 1 if seed==0; the LFSR never holds all-zero.
  - load_seed has priority over everything except rst.
  - In RUN or DELIVER it aborts the operation: return to IDLE, no gnt, step_cnt=0, rr_ptr unchanged.
  - load_seed and req in the same IDLE cycle: load wins; arbitration happens on the next IDLE cycle.
- IDLE:
  - If req!=0: winner = first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch winner into owner, step_cnt=0, go to RUN.
  - Otherwise stay in IDLE; the LFSR holds.
- RUN:
  - LFSR steps once per cycle; step_cnt increments.
  - After STEPS steps (step_cnt==STEPS-1 on the last step), go to DELIVER.
- DELIVER (one cycle):
  - rand_out = LFSR value; rand_valid=1; gnt[owner]=1.
  - rr_ptr = (owner+1) mod NREQ; next state IDLE.
  - rand_out holds its value until the next DELIVER. gnt and rand_valid are 0 outside DELIVER.
- Latency: req seen in IDLE at cycle t gives gnt/rand_valid at cycle t+STEPS+1.
  - Back-to-back service costs STEPS+2 cycles per word.
- Requester drops req after winning: the word is still delivered and rr_ptr still advances; the gnt pulse is simply unused.
- No starvation: a continuously held req is served within NREQ grants.

Decomposition:
- Shared package (lfsr_pkg) holds:
  - tap-mask constant function tap_mask(WIDTH) returning 8'hB8 / 17'h12000;
  - FSM state encodings IDLE=2'd0, RUN=2'd1, DELIVER=2'd2;
  - default RST_SEED.
- Sub-module lfsr_core: parameters WIDTH and RST_SEED; ports clk, rst, load, seed, step, q. It contains the zero-seed guard.
- The arbiter contains the FSM, round-robin pointer and step counter.

Test Plan:
- Seed and single request: WIDTH=8, STEPS=8, rst, then load_seed with seed=8'h01.
  - req=4'b0001 held: gnt=4'b0001 and rand_out=8'h1C exactly 9 cycles after req is sampled.
  - Continuing to hold req: next word 8'h4B.
- Zero seed: load seed=0, then one request → word equals the seed=1 result (8'h1C); LFSR never reads 0.
- Round robin: req=4'b1111 held continuously → grant order 0001, 0010, 0100, 1000, 0001.
  - With req=4'b1001 after a grant to 0: next grant goes to requester 3, then 0.
- Abort by load_seed: load_seed=1 in the 4th RUN cycle → no gnt, FSM returns to IDLE.
  - A held request is re-served from the new seed; rr_ptr is unchanged.
- Reset mid-operation: rst during RUN → all outputs 0 next cycle; LFSR=RST_SEED; the next grant goes to requester 0 first.
- WIDTH=17, STEPS=17, seed=17'h1: run 3 words → rand_valid pulses exactly every 19 cycles.
  - Each word matches the reference model using x^17+x^14+1.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random-number arbiter slice:
// tap masks per supported width, FSM state encoding and default reset seed.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DELIVER = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_RST_SEED = 1;

    // Fibonacci feedback taps: x^8+x^6+x^5+x^4+1 and x^17+x^14+1.
    function automatic logic [31:0] tap_mask(input int unsigned width);
        logic [31:0] mask;
        mask = '0;
        case (width)
            8:       mask = 32'h0000_00B8;
            17:      mask = 32'h0001_2000;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR shift register with seed load and zero-seed guard.
// The register can never hold all-zero: a zero seed is replaced by 1.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(DEFAULT_RST_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             fb;

    always_comb begin
        fb  = ^(q_q & TAPS);
        q_d = q_q;
        if (load) begin
            q_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            q_d = {q_q[WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter sharing one LFSR among NREQ requesters; each grant
// delivers a word produced by STEPS fresh LFSR shifts.
module lfsr_rand_arbiter
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned STEPS    = WIDTH,
    parameter int unsigned RST_SEED = DEFAULT_RST_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_seed,
    input  logic [WIDTH-1:0] seed,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] rand_out,
    output logic             rand_valid,
    output logic             busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IDX_W = PTR_W + 1;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NREQ - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] rand_hold_q, rand_hold_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [PTR_W-1:0] winner;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic             lfsr_step;
    logic             deliver;

    lfsr_core #(
        .WIDTH    (WIDTH),
        .RST_SEED (WIDTH'(RST_SEED))
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (load_seed),
        .seed (seed),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr_q} + IDX_W'(i);
            if (idx >= IDX_W'(NREQ)) begin
                idx = idx - IDX_W'(NREQ);
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        step_cnt_d = step_cnt_q;
        lfsr_step  = 1'b0;
        if (load_seed) begin
            state_d    = IDLE;
            step_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        owner_d    = winner;
                        step_cnt_d = '0;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    lfsr_step = 1'b1;
                    if (step_cnt_q == LAST_STEP) begin
                        step_cnt_d = '0;
                        state_d    = DELIVER;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                DELIVER: begin
                    rr_ptr_d = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A reset or seed load arriving in the DELIVER cycle suppresses the grant.
    always_comb begin
        deliver     = (state_q == DELIVER) && !rst && !load_seed;
        rand_hold_d = deliver ? lfsr_q : rand_hold_q;
        gnt         = '0;
        if (deliver) begin
            gnt[owner_q] = 1'b1;
        end
        rand_out   = deliver ? lfsr_q : rand_hold_q;
        rand_valid = deliver;
        busy       = (state_q == RUN) || (state_q == DELIVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            step_cnt_q  <= '0;
            rand_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            step_cnt_q  <= step_cnt_d;
            rand_hold_q <= rand_hold_d;
        end
    end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Scoreboard bench for lfsr_rand_arbiter: 8-bit and 17-bit instances, expected
// grants/words predicted from the polynomials and round-robin rule.
module tb_lfsr_rand_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned S8  = 8;
    localparam int unsigned S17 = 17;

    typedef struct {
        int          cyc;
        logic [3:0]  gnt;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst8, rst17, ld8, ld17, v8, v17, busy8, busy17;
    logic [7:0]  seed8, out8;
    logic [16:0] seed17, out17;
    logic [3:0]  req8, req17, gnt8, gnt17;

    int          cyc    = 0;
    int          checks = 0;
    int          fails  = 0;
    exp_t        q8[$];
    exp_t        q17[$];
    logic [31:0] m8, m17;
    int unsigned rr8;
    int          s8, s17;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lfsr_rand_arbiter #(.WIDTH(8), .NREQ(4), .STEPS(8), .RST_SEED(1)) dut8 (
        .clk(clk), .rst(rst8), .load_seed(ld8), .seed(seed8), .req(req8),
        .gnt(gnt8), .rand_out(out8), .rand_valid(v8), .busy(busy8)
    );

    lfsr_rand_arbiter #(.WIDTH(17), .NREQ(4), .STEPS(17), .RST_SEED(1)) dut17 (
        .clk(clk), .rst(rst17), .load_seed(ld17), .seed(seed17), .req(req17),
        .gnt(gnt17), .rand_out(out17), .rand_valid(v17), .busy(busy17)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Word after 'steps' shifts, feedback taken from the polynomial exponents.
    function automatic logic [31:0] model_word(input logic [31:0] start, input int unsigned w,
                                               input int unsigned steps);
        logic [31:0] v;
        logic [31:0] fb;
        v = start;
        for (int unsigned i = 0; i < steps; i++) begin
            if (w == 8) fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 32'h1;
            else        fb = ((v >> 16) ^ (v >> 13)) & 32'h1;
            v = ((v << 1) | fb) & ((32'h1 << w) - 32'h1);
        end
        return v;
    endfunction

    function automatic int unsigned rr_pick(input logic [3:0] r, input int unsigned ptr);
        for (int unsigned k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic load8(input logic [7:0] sd);
        wait_until(s8 - 1);
        ld8 = 1'b1;
        seed8 = sd;
        tick();
        ld8 = 1'b0;
        m8 = (sd == 8'h00) ? 32'h1 : {24'h0, sd};
        s8 = cyc + 1;
    endtask

    task automatic issue8(input logic [3:0] r, input bit drop, input bit use_want, input logic [7:0] want);
        exp_t        e;
        int unsigned w;
        if (s8 < cyc + 1) s8 = cyc + 1;
        wait_until(s8 - 1);
        req8 = r;
        w = rr_pick(r, rr8);
        m8 = model_word(m8, 8, S8);
        e.cyc  = s8 + S8;
        e.gnt  = 4'(1 << w);
        e.word = use_want ? {24'h0, want} : m8;
        q8.push_back(e);
        rr8 = (w + 1) % N;
        if (drop) begin
            tick();
            tick();
            req8 = '0;
        end
        wait_until(e.cyc);
        s8 = e.cyc + 2;
    endtask

    task automatic abort_load8(input logic [3:0] r, input logic [7:0] sd);
        if (s8 < cyc + 1) s8 = cyc + 1;
        wait_until(s8 - 1);
        req8 = r;
        wait_until(s8 + 3);
        ld8 = 1'b1;
        seed8 = sd;
        tick();
        ld8 = 1'b0;
        m8 = (sd == 8'h00) ? 32'h1 : {24'h0, sd};
        s8 = cyc + 1;
        @(negedge clk);
        chk("abort_busy8", busy8, 0);
    endtask

    task automatic reset8_mid(input logic [3:0] r);
        if (s8 < cyc + 1) s8 = cyc + 1;
        wait_until(s8 - 1);
        req8 = r;
        wait_until(s8 + 1);
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        m8 = 32'h1;
        rr8 = 0;
        s8 = cyc + 1;
        @(negedge clk);
        chk("midrst_gnt8", gnt8, 0);
        chk("midrst_out8", out8, 0);
        chk("midrst_valid8", v8, 0);
        chk("midrst_busy8", busy8, 0);
    endtask

    // Monitor: pops an expectation on its due cycle, otherwise demands quiet outputs.
    logic [31:0] last8 = '0;
    logic [31:0] last17 = '0;
    bit          pend8 = 1'b0;
    bit          pend17 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (pend8) last8 = '0;
            if (pend17) last17 = '0;
            pend8 = rst8;
            pend17 = rst17;
            if (q8.size() > 0 && q8[0].cyc == cyc) begin
                e = q8.pop_front();
                chk("valid8", v8, 1);
                chk("gnt8", gnt8, e.gnt);
                chk("word8", out8, e.word);
                last8 = e.word;
            end else begin
                chk("quiet_valid8", v8, 0);
                chk("quiet_gnt8", gnt8, 0);
                chk("hold8", out8, last8);
            end
            if (q17.size() > 0 && q17[0].cyc == cyc) begin
                e = q17.pop_front();
                chk("valid17", v17, 1);
                chk("gnt17", gnt17, e.gnt);
                chk("word17", out17, e.word);
                last17 = e.word;
            end else begin
                chk("quiet_valid17", v17, 0);
                chk("quiet_gnt17", gnt17, 0);
                chk("hold17", out17, last17);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst8 = 1'b1;  rst17 = 1'b1;
        ld8 = 1'b0;   ld17 = 1'b0;
        seed8 = '0;   seed17 = '0;
        req8 = '0;    req17 = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_gnt8", gnt8, 0);
        chk("rst_out8", out8, 0);
        chk("rst_valid8", v8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_out17", out17, 0);
        chk("rst_busy17", busy17, 0);
        tick();
        rst8 = 1'b0;
        rst17 = 1'b0;
        m8 = 32'h1;
        rr8 = 0;
        s8 = 0;

        // Seed 1, single requester held: known words.
        load8(8'h01);
        issue8(4'b0001, 1'b0, 1'b1, 8'h1C);
        issue8(4'b0001, 1'b0, 1'b1, 8'h4B);
        req8 = '0;

        // Zero seed behaves as seed 1.
        load8(8'h00);
        issue8(4'b0001, 1'b0, 1'b1, 8'h1C);
        req8 = '0;

        // Abort in the 4th RUN cycle; pointer (now 1) must survive.
        abort_load8(4'b0011, 8'h5A);
        issue8(4'b0011, 1'b0, 1'b0, 8'h00);
        req8 = '0;

        // Reset mid-RUN, then full round robin from requester 0.
        reset8_mid(4'b1111);
        issue8(4'b1111, 1'b0, 1'b1, 8'h1C);
        for (int i = 0; i < 4; i++) issue8(4'b1111, 1'b0, 1'b0, 8'h00);
        issue8(4'b1001, 1'b0, 1'b0, 8'h00);
        issue8(4'b1001, 1'b0, 1'b0, 8'h00);

        // Random traffic: seeds (some zero), gaps, drops after winning.
        for (int i = 0; i < 40; i++) begin
            int gap;
            if ($urandom_range(0, 5) == 0) begin
                req8 = '0;
                load8(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
            end
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                req8 = '0;
                if (s8 < cyc + 1) s8 = cyc + 1;
                s8 = s8 + gap;
            end
            issue8(4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0), 1'b0, 8'h00);
        end
        req8 = '0;

        // 17-bit instance: three back-to-back words from seed 1.
        ld17 = 1'b1;
        seed17 = 17'h1;
        tick();
        ld17 = 1'b0;
        m17 = 32'h1;
        s17 = cyc + 1;
        req17 = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            m17 = model_word(m17, 17, S17);
            e.cyc  = s17 + S17 + k * (S17 + 2);
            e.gnt  = 4'b0001;
            e.word = m17;
            q17.push_back(e);
        end
        wait_until(s17 + S17 + 2 * (S17 + 2));
        req17 = '0;

        wait_until(cyc + 30);
        @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q17_drained", q17.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
